mem_dside_ctrl: RTL and testbench

- MEM-stage data-side access controller. It converts the MEM-stage load/store request into an sram-like handshake (req/addr_ok/data_ok), raises a pipeline stall request while an access is outstanding, and captures read data.
- Its dm_o output feeds the MEM/WB register and, from there, the write-back stage's load-data extraction.
- Replaces the fixed-latency data SRAM path so that variable-latency memory can be attached.

---
 rtl/mem_dside_ctrl_pkg.sv | 21 ++
 rtl/mem_dside_ctrl.sv | 118 +++++++++++
 tb/tb_mem_dside_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dside_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-side access controller.
// Holds the state encoding, the transfer-size codes and the default bus widths.
package mem_dside_ctrl_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int BSEL_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } dside_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_dside_ctrl.sv
// MEM-stage data-side controller: turns a load/store into an sram-like
// req/addr_ok/data_ok transaction and stalls the pipeline while it is in flight.
module mem_dside_ctrl
    import mem_dside_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              mem_dce_i,
    input  logic [BSEL_W-1:0] mem_we_i,
    input  logic [BSEL_W-1:0] mem_dre_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_din_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] dm_o,
    output logic              stallreq_mem_o
);

    // Unrecognised enable patterns fall back to a full-word transfer.
    function automatic logic [1:0] size_enc(input logic [BSEL_W-1:0] be);
        logic [1:0] sz;
        case (be)
            4'b1111:                            sz = SIZE_W;
            4'b0011, 4'b1100:                   sz = SIZE_H;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = SIZE_B;
            default:                            sz = SIZE_W;
        endcase
        return sz;
    endfunction

    dside_state_e      state_q, state_d;
    logic              flush_seen_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dm_q;
    logic              new_acc;
    logic              req_flushed;

    always_comb begin
        state_d        = state_q;
        new_acc        = 1'b0;
        stallreq_mem_o = 1'b0;
        dm_o           = dm_q;
        req_flushed    = flush_seen_q | flush_i;

        case (state_q)
            ST_IDLE: begin
                new_acc        = mem_dce_i & ~flush_i;
                stallreq_mem_o = new_acc;
                if (new_acc) state_d = ST_REQ;
            end
            ST_REQ: begin
                // The request stays up until accepted; a flush only redirects the response.
                stallreq_mem_o = 1'b1;
                if (data_addr_ok) state_d = req_flushed ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    dm_o    = data_rdata;
                    state_d = stall_i ? ST_DONE : ST_IDLE;
                end else begin
                    stallreq_mem_o = 1'b1;
                    if (flush_i) state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!stall_i || flush_i) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                stallreq_mem_o = mem_dce_i;
                if (data_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q      <= ST_IDLE;
            flush_seen_q <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= SIZE_B;
            addr_q       <= '0;
            wdata_q      <= '0;
            dm_q         <= '0;
        end else begin
            state_q      <= state_d;
            flush_seen_q <= (state_q == ST_REQ) && !data_addr_ok && req_flushed;
            if (new_acc) begin
                wr_q    <= |mem_we_i;
                size_q  <= size_enc((|mem_we_i) ? mem_we_i : mem_dre_i);
                addr_q  <= mem_addr_i;
                wdata_q <= mem_din_i;
            end
            if ((state_q == ST_WAIT) && data_data_ok && !wr_q) dm_q <= data_rdata;
        end
    end

    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

endmodule

// File: tb/tb_mem_dside_ctrl.sv
// Self-checking bench for mem_dside_ctrl: table of size/direction vectors,
// hand-written corner sequences and a randomized run against a transaction model.
module tb_mem_dside_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              dce, flush, stall, aok, dok;
    logic [3:0]        we, dre;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din, rdata;
    logic              req_o, wr_o, stallreq_o;
    logic [1:0]        size_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o, dm_o;

    always #5 clk = ~clk;

    mem_dside_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .cpu_clk_50M(clk), .cpu_rst(rst),
        .mem_dce_i(dce), .mem_we_i(we), .mem_dre_i(dre),
        .mem_addr_i(addr), .mem_din_i(din),
        .flush_i(flush), .stall_i(stall),
        .data_req(req_o), .data_wr(wr_o), .data_size(size_o),
        .data_addr(addr_o), .data_wdata(wdata_o),
        .data_addr_ok(aok), .data_data_ok(dok), .data_rdata(rdata),
        .dm_o(dm_o), .stallreq_mem_o(stallreq_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: flags describe where the access is in its life.
    logic        m_pend, m_out, m_drop, m_hold, m_fseen;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_dm;

    function automatic logic [1:0] ref_size(input logic [3:0] be);
        int n = $countones(be);
        if (n == 1) return 2'd0;
        if (be == 4'b0011 || be == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_out = 0; m_drop = 0; m_hold = 0; m_fseen = 0;
        m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_dm = 0;
    endtask

    int stall_cnt, req_cnt;
    logic [31:0] last_dm;

    // One clock: compare against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic idle, newacc, e_stall;
        logic [31:0] e_dm;
        idle    = !m_pend && !m_out && !m_hold;
        newacc  = idle && dce && !flush;
        e_stall = newacc || m_pend || (m_out && !m_drop && !dok) || (m_out && m_drop && dce);
        e_dm    = (m_out && !m_drop && dok) ? rdata : m_dm;
        #3;
        chk("data_req", {31'd0, req_o}, {31'd0, m_pend});
        chk("stallreq", {31'd0, stallreq_o}, {31'd0, e_stall});
        chk("dm_o", dm_o, e_dm);
        chk("data_wr", {31'd0, wr_o}, {31'd0, m_wr});
        chk("data_size", {30'd0, size_o}, {30'd0, m_size});
        chk("data_addr", addr_o, m_addr);
        chk("data_wdata", wdata_o, m_wdata);
        if (stallreq_o) stall_cnt++;
        if (req_o) req_cnt++;
        last_dm = dm_o;
        @(posedge clk);
        if (rst) model_reset();
        else if (newacc) begin
            m_pend = 1; m_fseen = 0;
            m_wr = |we; m_size = ref_size((|we) ? we : dre);
            m_addr = addr; m_wdata = din;
        end else if (m_pend) begin
            if (aok) begin m_pend = 0; m_out = 1; m_drop = m_fseen || flush; end
            else m_fseen = m_fseen || flush;
        end else if (m_out) begin
            if (dok) begin
                if (!m_drop) begin
                    if (!m_wr) m_dm = rdata;
                    m_hold = stall;
                end
                m_out = 0; m_drop = 0;
            end else if (flush) m_drop = 1;
        end else if (m_hold) begin
            if (!stall || flush) m_hold = 0;
        end
        #1;
    endtask

    task automatic quiet();
        rst = 0; dce = 0; we = 0; dre = 0; addr = 0; din = 0;
        flush = 0; stall = 0; aok = 0; dok = 0; rdata = 0;
    endtask

    typedef struct {
        logic [3:0] we;
        logic [3:0] dre;
        logic [1:0] exp_size;
        logic       exp_wr;
    } vec_t;

    vec_t vecs[10];
    logic [3:0] we_pats[8];

    initial begin
        vecs[0] = '{4'b0000, 4'b1111, 2'd2, 1'b0};
        vecs[1] = '{4'b0000, 4'b1100, 2'd1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0011, 2'd1, 1'b0};
        vecs[3] = '{4'b0000, 4'b0110, 2'd2, 1'b0};
        vecs[4] = '{4'b0000, 4'b0001, 2'd0, 1'b0};
        vecs[5] = '{4'b0000, 4'b1000, 2'd0, 1'b0};
        vecs[6] = '{4'b1111, 4'b0000, 2'd2, 1'b1};
        vecs[7] = '{4'b0100, 4'b0000, 2'd0, 1'b1};
        vecs[8] = '{4'b0011, 4'b1111, 2'd1, 1'b1};
        vecs[9] = '{4'b0101, 4'b0001, 2'd2, 1'b1};
        we_pats = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};

        // Reset from power-up.
        quiet();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, req_o}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
        chk("rst_dm", dm_o, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_size_wr", {29'd0, size_o, wr_o}, 32'd0);
        rst = 0;

        // Size/direction table.
        for (int i = 0; i < 10; i++) begin
            dce = 1; we = vecs[i].we; dre = vecs[i].dre;
            addr = 32'h1000 + 32'(i * 4); din = 32'hA5A50000 + 32'(i);
            cycle();
            chk($sformatf("vec%0d_size", i), {30'd0, size_o}, {30'd0, vecs[i].exp_size});
            chk($sformatf("vec%0d_wr", i), {31'd0, wr_o}, {31'd0, vecs[i].exp_wr});
            aok = 1; cycle(); aok = 0;
            dok = 1; rdata = 32'h0BAD0000 + 32'(i); cycle(); dok = 0;
            dce = 0; cycle();
        end

        // Word load, minimum response timing.
        stall_cnt = 0;
        dce = 1; we = 0; dre = 4'hF; addr = 32'h80000040;
        cycle();
        chk("wload_size", {30'd0, size_o}, 32'd2);
        chk("wload_wr", {31'd0, wr_o}, 32'd0);
        aok = 1; cycle(); aok = 0;
        cycle();
        dok = 1; rdata = 32'h12345678; cycle(); dok = 0;
        chk("wload_stall_cycles", stall_cnt, 32'd3);
        chk("wload_dm_release", last_dm, 32'h12345678);
        dce = 0; cycle();

        // Byte store with delayed addr_ok.
        req_cnt = 0;
        dce = 1; we = 4'b0100; dre = 0; addr = 32'h80001003; din = 32'h0000AB00;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bstore_addr_stable", addr_o, 32'h80001003);
        end
        aok = 1; cycle(); aok = 0;
        chk("bstore_req_cycles", req_cnt, 32'd4);
        chk("bstore_size", {30'd0, size_o}, 32'd0);
        chk("bstore_wr", {31'd0, wr_o}, 32'd1);
        chk("bstore_wdata", wdata_o, 32'h0000AB00);
        dok = 1; cycle(); dok = 0;
        dce = 0; cycle();

        // Load completing under an external stall.
        dce = 1; we = 0; dre = 4'hF; addr = 32'h2000;
        cycle();
        aok = 1; cycle(); aok = 0;
        stall = 1; dok = 1; rdata = 32'hFEEDC0DE; cycle(); dok = 0; rdata = 32'h11111111;
        req_cnt = 0;
        cycle(); cycle();
        chk("done_no_reissue", req_cnt, 32'd0);
        chk("done_dm_hold", last_dm, 32'hFEEDC0DE);
        stall = 0; cycle();
        dce = 0; cycle();
        chk("done_back_idle", {31'd0, req_o}, 32'd0);

        // Flush in REQ before addr_ok, then a new load arriving during DRAIN.
        dce = 1; we = 0; dre = 4'hF; addr = 32'h3000;
        cycle();
        flush = 1; cycle(); flush = 0;
        dce = 0; cycle();
        chk("flush_req_held", {31'd0, req_o}, 32'd1);
        aok = 1; cycle(); aok = 0;
        dce = 1; addr = 32'h3400; req_cnt = 0;
        cycle();
        chk("drain_stallreq", {31'd0, stallreq_o}, 32'd1);
        dok = 1; rdata = 32'hDEADBEEF; cycle(); dok = 0;
        chk("drain_no_stale", {31'(last_dm == 32'hDEADBEEF)}, 32'd0);
        chk("drain_no_early_req", req_cnt, 32'd0);
        cycle();
        aok = 1; cycle(); aok = 0;
        chk("drain_new_req", req_cnt, 32'd1);
        dok = 1; rdata = 32'hCAFEF00D; cycle(); dok = 0;
        chk("drain_new_data", last_dm, 32'hCAFEF00D);
        dce = 0; cycle();

        // Reset during WAIT, then a late response.
        dce = 1; we = 0; dre = 4'hF; addr = 32'h4000;
        cycle();
        aok = 1; cycle(); aok = 0;
        rst = 1; cycle(); rst = 0;
        dce = 0; dok = 1; rdata = 32'h77777777;
        cycle(); dok = 0;
        chk("rstwait_dm", last_dm, 32'd0);
        chk("rstwait_addr", addr_o, 32'd0);
        chk("rstwait_stall", {31'd0, stallreq_o}, 32'd0);
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            dce   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) ? 4'b0000 : we_pats[$urandom_range(0, 7)];
            dre   = 4'($urandom_range(0, 15));
            addr  = $urandom;
            din   = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 2) == 0);
            aok   = m_pend && ($urandom_range(0, 2) == 0);
            dok   = m_out && ($urandom_range(0, 2) == 0);
            rdata = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
